// File: rtl/vector_list_reader.sv
// Walks a vector-list ROM from a base address, decodes move/draw entries, offsets and
// saturates coordinates, and hands commands to the draw engine over valid/ready.
module vector_list_reader #(
  parameter int ADDRESSWIDTH = 16,
  parameter int DATAWIDTH    = 18,
  parameter int MAX_LEN      = 256
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [ADDRESSWIDTH-1:0] base_addr,
  input  logic [7:0]              off_x,
  input  logic [7:0]              off_y,
  output logic [ADDRESSWIDTH-1:0] rom_addr,
  input  logic [DATAWIDTH-1:0]    rom_data,
  output logic                    cmd_valid,
  input  logic                    cmd_ready,
  output logic [7:0]              cmd_x,
  output logic [7:0]              cmd_y,
  output logic                    cmd_draw,
  output logic                    cmd_clip,
  output logic                    busy,
  output logic                    done,
  output logic                    err
);

  localparam int CntW = $clog2(MAX_LEN + 1);

  typedef enum logic [1:0] {StIdle, StFetch, StEmit, StDone} state_e;

  localparam logic [1:0] KindInvalid = 2'b00;
  localparam logic [1:0] KindEnd     = 2'b11;

  state_e                  state_q, state_d;
  logic [ADDRESSWIDTH-1:0] rom_addr_q, rom_addr_d;
  logic [7:0]              off_x_q, off_x_d;
  logic [7:0]              off_y_q, off_y_d;
  logic [CntW-1:0]         count_q, count_d;
  logic                    cmd_valid_q, cmd_valid_d;
  logic [7:0]              cmd_x_q, cmd_x_d;
  logic [7:0]              cmd_y_q, cmd_y_d;
  logic                    cmd_draw_q, cmd_draw_d;
  logic                    cmd_clip_q, cmd_clip_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    err_q, err_d;

  logic [1:0] kind;
  logic [8:0] sum_x, sum_y;
  logic       at_limit;

  assign kind     = rom_data[1:0];
  // 9-bit sums: the carry is both the saturation select and the clip flag.
  assign sum_x    = {1'b0, rom_data[DATAWIDTH-1 -: 8]} + {1'b0, off_x_q};
  assign sum_y    = {1'b0, rom_data[DATAWIDTH-9 -: 8]} + {1'b0, off_y_q};
  assign at_limit = (count_q == CntW'(MAX_LEN));

  always_comb begin
    state_d     = state_q;
    rom_addr_d  = rom_addr_q;
    off_x_d     = off_x_q;
    off_y_d     = off_y_q;
    count_d     = count_q;
    cmd_valid_d = cmd_valid_q;
    cmd_x_d     = cmd_x_q;
    cmd_y_d     = cmd_y_q;
    cmd_draw_d  = cmd_draw_q;
    cmd_clip_d  = cmd_clip_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    err_d       = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          rom_addr_d = base_addr;
          off_x_d    = off_x;
          off_y_d    = off_y;
          count_d    = '0;
          busy_d     = 1'b1;
          state_d    = StFetch;
        end
      end
      StFetch: begin
        // A clean end marker wins over the length limit.
        if (kind == KindEnd) begin
          done_d  = 1'b1;
          state_d = StDone;
        end else if (at_limit || kind == KindInvalid) begin
          done_d  = 1'b1;
          err_d   = 1'b1;
          state_d = StDone;
        end else begin
          cmd_x_d     = sum_x[8] ? 8'hff : sum_x[7:0];
          cmd_y_d     = sum_y[8] ? 8'hff : sum_y[7:0];
          cmd_draw_d  = rom_data[1];
          cmd_clip_d  = sum_x[8] | sum_y[8];
          cmd_valid_d = 1'b1;
          state_d     = StEmit;
        end
      end
      StEmit: begin
        if (cmd_ready) begin
          cmd_valid_d = 1'b0;
          rom_addr_d  = rom_addr_q + ADDRESSWIDTH'(1);
          count_d     = count_q + CntW'(1);
          state_d     = StFetch;
        end
      end
      StDone: begin
        busy_d  = 1'b0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      rom_addr_q  <= '0;
      off_x_q     <= '0;
      off_y_q     <= '0;
      count_q     <= '0;
      cmd_valid_q <= 1'b0;
      cmd_x_q     <= '0;
      cmd_y_q     <= '0;
      cmd_draw_q  <= 1'b0;
      cmd_clip_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      rom_addr_q  <= rom_addr_d;
      off_x_q     <= off_x_d;
      off_y_q     <= off_y_d;
      count_q     <= count_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_x_q     <= cmd_x_d;
      cmd_y_q     <= cmd_y_d;
      cmd_draw_q  <= cmd_draw_d;
      cmd_clip_q  <= cmd_clip_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign rom_addr  = rom_addr_q;
  assign cmd_valid = cmd_valid_q;
  assign cmd_x     = cmd_x_q;
  assign cmd_y     = cmd_y_q;
  assign cmd_draw  = cmd_draw_q;
  assign cmd_clip  = cmd_clip_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_vector_list_reader.sv
// Bench for vector_list_reader: table-driven object runs checked against a list-walking
// model, plus hand sequences for reset, ignored start and a MAX_LEN=4 instance.
module tb_vector_list_reader;

  typedef struct packed {
    logic [7:0] x;
    logic [7:0] y;
    logic       draw;
    logic       clip;
  } cmd_t;

  typedef struct {
    logic [15:0] base;
    logic [7:0]  ox;
    logic [7:0]  oy;
    int          mode;     // 0 ready high, 1 random ready, 2 stall 3 cycles on 2nd command
    int          poke;     // cycle at which a stray start is pulsed, 0 = none
    int          exp_n;
    logic        exp_err;
    int          exp_cyc;  // -1 = not checked
    logic        chk01;
    cmd_t        c0;
    cmd_t        c1;
  } vec_t;

  logic        clk, rst, start;
  logic [15:0] base_addr, rom_addr;
  logic [7:0]  off_x, off_y, cmd_x, cmd_y;
  logic [17:0] rom_data;
  logic        cmd_valid, cmd_ready, cmd_draw, cmd_clip, busy, done, err;

  logic        start2, cmd_ready2, cmd_valid2, cmd_draw2, cmd_clip2, busy2, done2, err2;
  logic [15:0] base2, rom_addr2;
  logic [7:0]  cmd_x2, cmd_y2;
  logic [17:0] rom_data2;

  logic [17:0] rom [0:65535];
  cmd_t        got_q[$];
  cmd_t        exp_q[$];
  int          n_vec, n_bad;

  assign rom_data  = rom[rom_addr];
  assign rom_data2 = rom[rom_addr2];

  vector_list_reader dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .off_x(off_x), .off_y(off_y),
    .rom_addr(rom_addr), .rom_data(rom_data), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_draw(cmd_draw), .cmd_clip(cmd_clip), .busy(busy),
    .done(done), .err(err)
  );

  vector_list_reader #(.MAX_LEN(4)) dut_ml (
    .clk(clk), .rst(rst), .start(start2), .base_addr(base2), .off_x(8'd0), .off_y(8'd0),
    .rom_addr(rom_addr2), .rom_data(rom_data2), .cmd_valid(cmd_valid2),
    .cmd_ready(cmd_ready2), .cmd_x(cmd_x2), .cmd_y(cmd_y2), .cmd_draw(cmd_draw2),
    .cmd_clip(cmd_clip2), .busy(busy2), .done(done2), .err(err2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic cmd_t mk(input int x, input int y, input bit d, input bit c);
    mk = '{x: 8'(x), y: 8'(y), draw: d, clip: c};
  endfunction

  function automatic logic [17:0] ent(input int x, input int y, input logic [1:0] k);
    ent = {8'(x), 8'(y), k};
  endfunction

  // Reference: walk the list, saturate sums at 255, stop on end / invalid / length limit.
  function automatic logic model(input logic [15:0] base, input logic [7:0] ox,
                                 input logic [7:0] oy, input int max_len);
    int a, n, sx, sy;
    logic [17:0] w;
    exp_q.delete();
    a = int'(base);
    n = 0;
    for (int guard = 0; guard < 70000; guard++) begin
      w = rom[a];
      if (w[1:0] == 2'b11) return 1'b0;
      if (n == max_len || w[1:0] == 2'b00) return 1'b1;
      sx = int'(w[17:10]) + int'(ox);
      sy = int'(w[9:2]) + int'(oy);
      exp_q.push_back(mk(sx > 255 ? 255 : sx, sy > 255 ? 255 : sy, w[1],
                         sx > 255 || sy > 255));
      n++;
      a = (a + 1) % 65536;
    end
    return 1'b1;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic compare_lists(input string name, input logic exp_err, input logic got_err);
    check({name, " count"}, 32'(got_q.size()), 32'(exp_q.size()));
    check({name, " err"}, 32'(got_err), 32'(exp_err));
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      check($sformatf("%s cmd%0d", name, i), 32'(got_q[i]), 32'(exp_q[i]));
  endtask

  task automatic run_obj(input logic [15:0] base, input logic [7:0] ox, input logic [7:0] oy,
                         input int mode, input int poke, output int cyc, output logic got_err);
    cmd_t cur, prev;
    logic prev_stall, fin;
    int   stall, k;
    got_q.delete();
    @(negedge clk);
    start = 1'b1; base_addr = base; off_x = ox; off_y = oy; cmd_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    check("busy after start", 32'(busy), 32'd1);
    check("rom_addr after start", 32'(rom_addr), 32'(base));
    prev_stall = 1'b0; prev = '0; fin = 1'b0; stall = 0; k = 0; got_err = 1'b0;
    while (!fin) begin
      cur = cmd_t'({cmd_x, cmd_y, cmd_draw, cmd_clip});
      if (prev_stall) begin
        check("stall valid held", 32'(cmd_valid), 32'd1);
        check("stall cmd stable", 32'(cur), 32'(prev));
      end
      if (err && !done) check("err without done", 32'(done), 32'd1);
      if (done) begin
        fin = 1'b1;
        got_err = err;
        check("busy at done", 32'(busy), 32'd1);
      end else if (cyc > 3000) begin
        check("timeout waiting done", 32'(done), 32'd1);
        fin = 1'b1;
      end else begin
        if (mode == 1) cmd_ready = 1'($urandom_range(0, 1));
        else if (mode == 2 && cmd_valid && k == 1 && stall < 3) begin
          cmd_ready = 1'b0;
          stall++;
        end else cmd_ready = 1'b1;
        start = (poke != 0 && cyc == poke);
        if (start) base_addr = 16'd69;
        prev_stall = cmd_valid && !cmd_ready;
        prev = cur;
        if (cmd_valid && cmd_ready) begin
          got_q.push_back(cur);
          k++;
        end
        @(negedge clk);
        start = 1'b0;
        cyc++;
      end
    end
    cmd_ready = 1'b1;
    @(negedge clk);
    check("done cleared", 32'(done), 32'd0);
    check("busy cleared", 32'(busy), 32'd0);
  endtask

  vec_t tbl [9];

  initial begin
    int          cyc, k;
    logic        got_err, exp_err;
    logic [15:0] b;
    int          len;

    n_vec = 0; n_bad = 0;
    rst = 1'b1; start = 1'b0; base_addr = '0; off_x = '0; off_y = '0; cmd_ready = 1'b1;
    start2 = 1'b0; base2 = '0; cmd_ready2 = 1'b1;
    for (int i = 0; i < 65536; i++) rom[i] = '0;
    rom[0] = ent(3, 4, 2'b10);
    rom[1] = ent(9, 9, 2'b11);
    rom[65534] = ent(250, 5, 2'b01);
    rom[65535] = ent(251, 6, 2'b10);
    for (int i = 0; i < 10; i++)
      rom[10 + i] = ent(i * 20, 200 - i * 15, (i % 3 == 0) ? 2'b01 : 2'b10);
    rom[20] = ent(0, 0, 2'b11);
    rom[42] = ent(0, 254, 2'b01);
    rom[43] = ent(0, 0, 2'b10);
    rom[44] = ent(254, 0, 2'b10);
    rom[45] = ent(254, 254, 2'b10);
    rom[46] = ent(0, 254, 2'b10);
    rom[47] = ent(77, 77, 2'b11);
    rom[48] = ent(22, 100, 2'b01);
    rom[49] = ent(46, 200, 2'b10);
    rom[50] = ent(0, 0, 2'b11);
    for (int i = 0; i < 300; i++) rom[2000 + i] = ent(i, 255 - (i % 256), 2'b10);

    tbl[0] = '{base: 42, ox: 0, oy: 0, mode: 0, poke: 0, exp_n: 5, exp_err: 0, exp_cyc: 12,
               chk01: 1, c0: mk(0, 254, 0, 0), c1: mk(0, 0, 1, 0)};
    tbl[1] = '{base: 48, ox: 10, oy: 220, mode: 0, poke: 0, exp_n: 2, exp_err: 0, exp_cyc: 6,
               chk01: 1, c0: mk(32, 255, 0, 1), c1: mk(56, 255, 1, 1)};
    tbl[2] = '{base: 42, ox: 0, oy: 0, mode: 2, poke: 0, exp_n: 5, exp_err: 0, exp_cyc: 15,
               chk01: 1, c0: mk(0, 254, 0, 0), c1: mk(0, 0, 1, 0)};
    tbl[3] = '{base: 69, ox: 0, oy: 0, mode: 0, poke: 0, exp_n: 0, exp_err: 1, exp_cyc: 2,
               chk01: 0, c0: '0, c1: '0};
    tbl[4] = '{base: 42, ox: 0, oy: 0, mode: 0, poke: 4, exp_n: 5, exp_err: 0, exp_cyc: 12,
               chk01: 1, c0: mk(0, 254, 0, 0), c1: mk(0, 0, 1, 0)};
    tbl[5] = '{base: 10, ox: 5, oy: 7, mode: 0, poke: 0, exp_n: 10, exp_err: 0, exp_cyc: 22,
               chk01: 0, c0: '0, c1: '0};
    tbl[6] = '{base: 65534, ox: 0, oy: 0, mode: 0, poke: 0, exp_n: 3, exp_err: 0, exp_cyc: 8,
               chk01: 1, c0: mk(250, 5, 0, 0), c1: mk(251, 6, 1, 0)};
    tbl[7] = '{base: 2000, ox: 0, oy: 0, mode: 0, poke: 0, exp_n: 256, exp_err: 1,
               exp_cyc: 514, chk01: 0, c0: '0, c1: '0};
    tbl[8] = '{base: 10, ox: 240, oy: 100, mode: 1, poke: 0, exp_n: 10, exp_err: 0,
               exp_cyc: -1, chk01: 0, c0: '0, c1: '0};

    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("reset rom_addr", 32'(rom_addr), 32'd0);
    check("reset cmd_valid", 32'(cmd_valid), 32'd0);
    check("reset cmd_xy", 32'({cmd_x, cmd_y, cmd_draw, cmd_clip}), 32'd0);
    check("reset busy/done/err", 32'({busy, done, err}), 32'd0);

    for (int t = 0; t < 9; t++) begin
      run_obj(tbl[t].base, tbl[t].ox, tbl[t].oy, tbl[t].mode, tbl[t].poke, cyc, got_err);
      exp_err = model(tbl[t].base, tbl[t].ox, tbl[t].oy, 256);
      compare_lists($sformatf("row%0d", t), exp_err, got_err);
      check($sformatf("row%0d table count", t), 32'(got_q.size()), 32'(tbl[t].exp_n));
      check($sformatf("row%0d table err", t), 32'(got_err), 32'(tbl[t].exp_err));
      if (tbl[t].exp_cyc >= 0)
        check($sformatf("row%0d start-to-done cycles", t), 32'(cyc), 32'(tbl[t].exp_cyc));
      if (tbl[t].chk01 && got_q.size() >= 2) begin
        check($sformatf("row%0d first cmd", t), 32'(got_q[0]), 32'(tbl[t].c0));
        check($sformatf("row%0d second cmd", t), 32'(got_q[1]), 32'(tbl[t].c1));
      end
    end

    // Random objects, random offsets, random backpressure.
    for (int t = 0; t < 12; t++) begin
      b = 16'(3000 + t * 64);
      len = $urandom_range(0, 40);
      for (int i = 0; i < len; i++)
        rom[b + 16'(i)] = {16'($urandom), $urandom_range(0, 1) ? 2'b01 : 2'b10};
      if ($urandom_range(0, 7) == 0) rom[b + 16'(len)] = {16'($urandom), 2'b00};
      else rom[b + 16'(len)] = {16'($urandom), 2'b11};
      run_obj(b, 8'($urandom), 8'($urandom), 1, 0, cyc, got_err);
      exp_err = model(b, 8'(off_x), 8'(off_y), 256);
      compare_lists($sformatf("rand%0d", t), exp_err, got_err);
    end

    // Reset while the 3rd frame command is waiting for ready.
    @(negedge clk);
    start = 1'b1; base_addr = 16'd42; off_x = 8'd0; off_y = 8'd0; cmd_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k = 0;
    for (int c = 0; c < 100; c++) begin
      if (cmd_valid && k == 2) break;
      if (cmd_valid) k++;
      @(negedge clk);
    end
    check("reached 3rd cmd", 32'({cmd_valid, cmd_x}), 32'({1'b1, 8'd254}));
    cmd_ready = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; cmd_ready = 1'b1;
    check("midrst rom_addr", 32'(rom_addr), 32'd0);
    check("midrst cmd", 32'({cmd_valid, cmd_x, cmd_y, cmd_draw, cmd_clip}), 32'd0);
    check("midrst busy/done/err", 32'({busy, done, err}), 32'd0);
    @(negedge clk);
    check("midrst no done", 32'({busy, done}), 32'd0);
    run_obj(16'd48, 8'd10, 8'd220, 0, 0, cyc, got_err);
    exp_err = model(16'd48, 8'd10, 8'd220, 256);
    compare_lists("after reset", exp_err, got_err);
    check("after reset cycles", 32'(cyc), 32'd6);

    // MAX_LEN=4 instance on the map object.
    got_q.delete();
    @(negedge clk);
    start2 = 1'b1; base2 = 16'd10;
    @(negedge clk);
    start2 = 1'b0;
    got_err = 1'b0;
    for (int c = 0; c < 200; c++) begin
      if (done2) begin
        got_err = err2;
        break;
      end
      if (cmd_valid2) got_q.push_back(cmd_t'({cmd_x2, cmd_y2, cmd_draw2, cmd_clip2}));
      @(negedge clk);
    end
    check("maxlen4 done seen", 32'(done2), 32'd1);
    exp_err = model(16'd10, 8'd0, 8'd0, 4);
    compare_lists("maxlen4", exp_err, got_err);
    check("maxlen4 count const", 32'(got_q.size()), 32'd4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
